// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_prefetch_queue_if #(
  parameter int PC_W = 9,
  parameter int IW   = 32
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [IW-1:0]   rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: owns fetch PC, issues in-order imem requests, buffers words in a FIFO.
// Define IF_PREFETCH_PERF_EN to add saturating redirect and empty-cycle counters.
module if_prefetch_queue #(
  parameter int PC_W    = 9,
  parameter int IW      = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2,
  parameter int PC_STEP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_i,
  input  logic [PC_W-1:0]              redirect_pc_i,
  input  logic                         stall_i,
  if_prefetch_queue_if.master          imem,
  output logic [IW-1:0]                inst_o,
  output logic [PC_W-1:0]              inst_pc_o,
  output logic                         inst_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [15:0]                  perf_flush_o,
  output logic [15:0]                  perf_empty_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [IW-1:0] NOP = IW'(32'h0000_0013);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [OW-1:0]   outstanding, outstanding_nxt;
  logic [OW-1:0]   discard, discard_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [AW-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [TW-1:0]   tag_wr, tag_wr_nxt, tag_rd, tag_rd_nxt;
  logic            armed;

  logic [PC_W-1:0] tag_q     [MAX_OUT];
  logic [PC_W-1:0] fifo_pc   [DEPTH];
  logic [IW-1:0]   fifo_data [DEPTH];

  logic credit_ok, issue, resp, push, pop;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  always_comb begin
    credit_ok = (outstanding < OW'(MAX_OUT)) &&
                ((int'(count) + int'(outstanding)) < DEPTH);
    imem.req  = rst_n && (state == FETCH) && credit_ok;
    imem.addr = fetch_pc;
    issue     = imem.req && imem.gnt;
    // A response with nothing outstanding is a stray (e.g. from before reset) and is dropped.
    resp      = (state == FETCH) && imem.rvalid && (outstanding != '0);
    push      = resp && !redirect_i;
    pop       = inst_valid_o && !stall_i && !redirect_i;
  end

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    outstanding_nxt = outstanding;
    discard_nxt     = discard;
    count_nxt       = count;
    wr_ptr_nxt      = wr_ptr;
    rd_ptr_nxt      = rd_ptr;
    tag_wr_nxt      = tag_wr;
    tag_rd_nxt      = tag_rd;
    if (redirect_i) begin
      fetch_pc_nxt    = redirect_pc_i;
      outstanding_nxt = '0;
      count_nxt       = '0;
      wr_ptr_nxt      = '0;
      rd_ptr_nxt      = '0;
      tag_wr_nxt      = '0;
      tag_rd_nxt      = '0;
      // Everything still in flight, including a grant taken this cycle, must be thrown away.
      if (state == FETCH)
        discard_nxt = outstanding + OW'(issue) - OW'(resp);
      else
        discard_nxt = discard - OW'(imem.rvalid && (discard != '0));
      state_nxt = (discard_nxt != '0) ? DRAIN : FETCH;
    end else if (state == DRAIN) begin
      discard_nxt = discard - OW'(imem.rvalid && (discard != '0));
      if (discard_nxt == '0)
        state_nxt = FETCH;
    end else begin
      if (issue) begin
        fetch_pc_nxt = fetch_pc + PC_W'(PC_STEP);
        tag_wr_nxt   = tag_inc(tag_wr);
      end
      if (resp)
        tag_rd_nxt = tag_inc(tag_rd);
      if (push)
        wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)
        rd_ptr_nxt = rd_ptr + AW'(1);
      outstanding_nxt = outstanding + OW'(issue) - OW'(resp);
      count_nxt       = count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      fetch_pc    <= '0;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      armed       <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      count       <= count_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      tag_wr      <= tag_wr_nxt;
      tag_rd      <= tag_rd_nxt;
      armed       <= armed | issue;
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      tag_q[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_pc[wr_ptr]   <= tag_q[tag_rd];
      fifo_data[wr_ptr] <= imem.rdata;
    end
  end

  always_comb begin
    inst_valid_o = (count != '0);
    inst_o       = inst_valid_o ? fifo_data[rd_ptr] : NOP;
    inst_pc_o    = inst_valid_o ? fifo_pc[rd_ptr] : '0;
    count_o      = count;
  end

`ifdef IF_PREFETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_flush_o <= '0;
      perf_empty_o <= '0;
    end else begin
      perf_flush_o <= sat_inc(perf_flush_o, redirect_i);
      perf_empty_o <= sat_inc(perf_empty_o, !inst_valid_o && !stall_i);
    end
  end
`endif

  // Strays are only tolerated before the first grant after reset (pre-reset responses).
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    (armed && (state == FETCH) && imem.rvalid) |-> (outstanding != '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Scoreboard bench for if_prefetch_queue: randomized imem timing, redirects and stalls.
module tb_if_prefetch_queue;
  localparam int PC_W    = 9;
  localparam int IW      = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int PC_STEP = 1;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_pc_i;
  logic            stall_i;
  logic [IW-1:0]   inst_o;
  logic [PC_W-1:0] inst_pc_o;
  logic            inst_valid_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
`ifdef IF_PREFETCH_PERF_EN
  logic [15:0] perf_flush_o, perf_empty_o;
`endif

  if_prefetch_queue_if #(.PC_W(PC_W), .IW(IW)) bus ();

  if_prefetch_queue #(.PC_W(PC_W), .IW(IW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .PC_STEP(PC_STEP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem          (bus),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_valid_o  (inst_valid_o),
    .count_o       (count_o)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_flush_o  (perf_flush_o),
    .perf_empty_o  (perf_empty_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [PC_W-1:0] addr; int due; } rsp_t;
  typedef struct { logic [PC_W-1:0] pc; logic [IW-1:0] data; } exp_t;

  rsp_t rsp_q[$];        // memory-side responses still to be returned, in order
  exp_t exp_q[$];        // instructions the fetch stage still owes to decode, in order
  logic [PC_W-1:0] model_pc;
  int cyc, ghost, stale, nredir;
  int lat_min, lat_max;
  int n_checks, n_pass;

  function automatic logic [IW-1:0] mem_word(input logic [PC_W-1:0] a);
    return (IW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of stimulus. Responses are classified front-to-back as ghosts (issued before a
  // reset), stale (issued before a redirect) or live; only live ones become instructions.
  task automatic drive(input bit redir, input logic [PC_W-1:0] rpc, input bit stl, input bit g);
    bit exp_req;
    int inflight;
    @(posedge clk); #1;
    cyc++;
    inflight = rsp_q.size() - ghost - stale;
    exp_req  = (stale == 0) && (inflight < MAX_OUT) && (exp_q.size() < DEPTH);
    check("imem_req", 64'(bus.req), 64'(exp_req));
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = mem_word(rsp_q[0].addr);
      void'(rsp_q.pop_front());
      if (ghost > 0) ghost--;
      else if (stale > 0) stale--;
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
    end
    redirect_i    = redir;
    redirect_pc_i = rpc;
    stall_i       = stl;
    bus.gnt       = g;
    if (bus.req && g) begin
      check("imem_addr", 64'(bus.addr), 64'(model_pc));
      exp_q.push_back('{model_pc, mem_word(model_pc)});
      rsp_q.push_back('{bus.addr, cyc + int'($urandom_range(lat_max, lat_min))});
      model_pc = model_pc + PC_W'(PC_STEP);
    end
    if (redir) begin
      exp_q.delete();
      model_pc = rpc;
      stale    = rsp_q.size() - ghost;
      nredir++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    exp_q.delete();
    model_pc = '0; stale = 0; nredir = 0;
    ghost = rsp_q.size();
    #1;
    check("rst_req", 64'(bus.req), 64'(0));
    check("rst_addr", 64'(bus.addr), 64'(0));
    check("rst_inst", 64'(inst_o), 64'(NOP));
    check("rst_pc", 64'(inst_pc_o), 64'(0));
    check("rst_valid", 64'(inst_valid_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: every instruction taken by decode must be the next one owed.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (inst_valid_o && !stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL consume: got pc %0h with nothing owed (cycle %0d)", inst_pc_o, cyc);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", 64'(inst_pc_o), 64'(e.pc));
          check("inst", 64'(inst_o), 64'(e.data));
        end
      end else if (!inst_valid_o) begin
        check("empty_inst", 64'(inst_o), 64'(NOP));
        check("empty_pc", 64'(inst_pc_o), 64'(0));
      end
      check("valid_vs_count", 64'(inst_valid_o), 64'(count_o != '0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; ghost = 0; stale = 0; nredir = 0;
    rsp_q.delete(); exp_q.delete();
    rst_n = 1'b0;
    lat_min = 1; lat_max = 1;
    do_reset();

    // Decode stalled: queue fills to DEPTH, requests stop, head holds PC 0.
    repeat (10) drive(1'b0, '0, 1'b1, 1'b1);
    #1;
    check("full_count", 64'(count_o), 64'(DEPTH));
    check("full_req", 64'(bus.req), 64'(0));
    check("full_head_pc", 64'(inst_pc_o), 64'(0));
    check("full_head_inst", 64'(inst_o), 64'(mem_word('0)));

    repeat (20) drive(1'b0, '0, 1'b0, 1'b1);

    // Slow memory keeps two requests in flight when the redirect lands.
    lat_min = 4; lat_max = 4;
    repeat (6) drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 9'h040, 1'b0, 1'b1);
    lat_min = 1; lat_max = 2;
    repeat (20) drive(1'b0, '0, 1'b0, 1'b1);

    // Redirect coinciding with a response and a fresh grant.
    lat_min = 1; lat_max = 1;
    repeat (5) drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 9'h100, 1'b0, 1'b1);
    repeat (10) drive(1'b0, '0, 1'b0, 1'b1);

    // PC wrap across 9'h1FF.
    drive(1'b1, 9'h1FD, 1'b0, 1'b1);
    repeat (14) drive(1'b0, '0, 1'b0, 1'b1);

    lat_min = 1; lat_max = 4;
    repeat (500) begin
      logic [PC_W-1:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? PC_W'(9'h1FC + $urandom_range(0, 3)) : PC_W'($urandom);
      drive($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
    end

    // Reset with requests in flight; their late responses must be ignored.
    lat_min = 1; lat_max = 1;
    repeat (8) drive(1'b0, '0, 1'b0, 1'b0);
    lat_min = 8; lat_max = 8;
    repeat (3) drive(1'b0, '0, 1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 20 && rsp_q.size() > 0; i++) drive(1'b0, '0, 1'b0, 1'b0);
    check("late_rsp_drained", 64'(rsp_q.size()), 64'(0));
    #1;
    check("late_count", 64'(count_o), 64'(0));
    check("late_valid", 64'(inst_valid_o), 64'(0));
    check("late_inst", 64'(inst_o), 64'(NOP));

    lat_min = 1; lat_max = 3;
    repeat (10) drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 9'h010, 1'b0, 1'b1);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 9'h020, 1'b0, 1'b1);
    repeat (4) drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 9'h030, 1'b0, 1'b1);
    repeat (12) drive(1'b0, '0, 1'b0, 1'b1);
`ifdef IF_PREFETCH_PERF_EN
    check("perf_flush", 64'(perf_flush_o), 64'(nredir));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
